// File: rtl/parallel_to_serial_framer_pkg.sv
// Shared definitions for the parallel-to-serial framer and its serial-to-parallel receiver.
package parallel_to_serial_framer_pkg;

    localparam int unsigned DefaultWidth          = 8;
    localparam int unsigned DefaultFrameSizeWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StShift
    } state_e;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parallel_to_serial_framer_if.sv
// Control, word handshake and status signals of the framer, grouped for port use.
interface parallel_to_serial_framer_if
    import parallel_to_serial_framer_pkg::*;
#(
    parameter int unsigned WIDTH            = DefaultWidth,
    parameter int unsigned FRAME_SIZE_WIDTH = DefaultFrameSizeWidth
);

    logic                        enable;
    logic                        start;
    logic [FRAME_SIZE_WIDTH-1:0] framesize;
    logic [WIDTH-1:0]            parallel;
    logic                        word_valid;
    logic                        word_ready;
    logic                        serial_oe;
    logic                        busy;
    logic                        complete;
    logic                        underrun;

    modport master (
        output enable, start, framesize, parallel, word_valid,
        input  word_ready, serial_oe, busy, complete, underrun
    );

    modport slave (
        input  enable, start, framesize, parallel, word_valid,
        output word_ready, serial_oe, busy, complete, underrun
    );

endinterface

// File: rtl/piso_shift_register.sv
// Parallel-load, shift-left register presenting its MSB as the serial bit.
module piso_shift_register #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/parallel_to_serial_framer.sv
// Frames a stream of parallel words onto a tristated serial line, MSB first, with
// per-frame bit count, gapless word chaining, completion and underrun pulses.
module parallel_to_serial_framer
    import parallel_to_serial_framer_pkg::*;
#(
    parameter int unsigned WIDTH            = DefaultWidth,
    parameter int unsigned FRAME_SIZE_WIDTH = DefaultFrameSizeWidth
) (
    input  logic                         clk,
    input  logic                         rst,
    parallel_to_serial_framer_if.slave   bus,
    output wire                          serial
);

    localparam int unsigned              WordCntWidth = cnt_width(WIDTH);
    localparam logic [WordCntWidth-1:0]  WordLast     = WordCntWidth'(WIDTH - 1);

    state_e                      state_q, state_d;
    logic [FRAME_SIZE_WIDTH-1:0] fs_q, fs_d;
    logic [FRAME_SIZE_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [WordCntWidth-1:0]     word_cnt_q, word_cnt_d;
    logic                        complete_q, complete_d;
    logic                        underrun_q, underrun_d;

    logic sr_load, sr_shift, sr_msb;
    logic last_bit, word_end, word_ready, serial_oe;

    assign last_bit = (bit_cnt_q == fs_q - FRAME_SIZE_WIDTH'(1));
    assign word_end = (word_cnt_q == WordLast);

    always_comb begin
        state_d    = state_q;
        fs_d       = fs_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        complete_d = 1'b0;
        underrun_d = 1'b0;
        word_ready = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && bus.enable && (bus.framesize != '0)) begin
                    fs_d       = bus.framesize;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                word_ready = 1'b1;
                if (bus.word_valid) begin
                    sr_load = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                // Frame end takes precedence over a coinciding word boundary.
                if (last_bit) begin
                    complete_d = 1'b1;
                    state_d    = StIdle;
                end else if (word_end) begin
                    word_ready = 1'b1;
                    if (bus.word_valid) begin
                        sr_load    = 1'b1;
                        bit_cnt_d  = bit_cnt_q + FRAME_SIZE_WIDTH'(1);
                        word_cnt_d = '0;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = StIdle;
                    end
                end else begin
                    sr_shift   = 1'b1;
                    bit_cnt_d  = bit_cnt_q + FRAME_SIZE_WIDTH'(1);
                    word_cnt_d = word_cnt_q + WordCntWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fs_q       <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            complete_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fs_q       <= fs_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            complete_q <= complete_d;
            underrun_q <= underrun_d;
        end
    end

    piso_shift_register #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .rst     (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .data_i  (bus.parallel),
        .msb_o   (sr_msb)
    );

    assign serial_oe      = (state_q == StShift);
    assign serial         = serial_oe ? sr_msb : 1'bz;
    assign bus.serial_oe  = serial_oe;
    assign bus.word_ready = word_ready;
    assign bus.busy       = (state_q != StIdle);
    assign bus.complete   = complete_q;
    assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_parallel_to_serial_framer.sv
// Directed bench for the framer: a queue-based line model checked every cycle,
// plus literal per-frame expectations for the bit stream, pulses and latency.
module tb_parallel_to_serial_framer;
    import parallel_to_serial_framer_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned FSW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire  serial;

    parallel_to_serial_framer_if #(.WIDTH(W), .FRAME_SIZE_WIDTH(FSW)) fw ();

    parallel_to_serial_framer #(
        .WIDTH            (W),
        .FRAME_SIZE_WIDTH (FSW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (fw),
        .serial (serial)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic cmp1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp32(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Line model: a frame is a bit budget plus a queue of word bits waiting to go out.
    bit m_busy, m_fetch, m_cmp, m_und;
    int m_left;
    bit m_bits[$];

    function automatic bit m_ready();
        return m_fetch || (m_bits.size() == 1 && m_left > 1);
    endfunction

    task automatic m_load(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) m_bits.push_back(w[i]);
    endtask

    initial forever begin
        bit rdy;
        @(posedge clk);
        cyc++;
        rdy   = m_ready();
        m_cmp = 1'b0;
        m_und = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
            m_fetch = 1'b0;
            m_left = 0;
            m_bits.delete();
        end else if (!m_busy) begin
            if (fw.start && fw.enable && fw.framesize != 0) begin
                m_busy  = 1'b1;
                m_fetch = 1'b1;
                m_left  = int'(fw.framesize);
            end
        end else if (m_fetch) begin
            if (fw.word_valid) begin
                m_load(fw.parallel);
                m_fetch = 1'b0;
            end
        end else begin
            void'(m_bits.pop_front());
            m_left--;
            if (m_left == 0) begin
                m_cmp  = 1'b1;
                m_busy = 1'b0;
                m_bits.delete();
            end else if (m_bits.size() == 0) begin
                if (rdy && fw.word_valid) m_load(fw.parallel);
                else begin
                    m_und  = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    end

    // Observations of the actual line for the literal per-frame checks.
    bit line_q[$];
    int cmp_seen, und_seen, first_oe_cyc, cmp_cyc, acc_cyc;

    task automatic clear_obs();
        line_q.delete();
        cmp_seen = 0;
        und_seen = 0;
        first_oe_cyc = -1;
        cmp_cyc = -1;
        acc_cyc = -1;
    endtask

    initial forever begin
        bit e_oe;
        @(negedge clk);
        if (chk_en) begin
            e_oe = (m_bits.size() > 0);
            cmp1("busy", fw.busy, m_busy);
            cmp1("serial_oe", fw.serial_oe, e_oe);
            cmp1("word_ready", fw.word_ready, m_ready());
            cmp1("complete", fw.complete, m_cmp);
            cmp1("underrun", fw.underrun, m_und);
            cmp1("cmp_und_exclusive", fw.complete & fw.underrun, 1'b0);
            if (e_oe) cmp1("serial", serial, m_bits[0]);
            if (fw.serial_oe === 1'b1) begin
                line_q.push_back(serial);
                if (first_oe_cyc < 0) first_oe_cyc = cyc;
            end
            if (fw.complete === 1'b1) begin
                cmp_seen++;
                if (cmp_cyc < 0) cmp_cyc = cyc;
            end
            if (fw.underrun === 1'b1) und_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [FSW-1:0] fs, input bit en);
        fw.framesize = fs;
        fw.enable    = en;
        fw.start     = 1'b1;
        tick();
        fw.start  = 1'b0;
        fw.enable = 1'b1;
    endtask

    // Called just after a rising edge; returns just after the edge that took the word.
    task automatic send_word(input logic [W-1:0] w);
        bit done = 1'b0;
        fw.parallel   = w;
        fw.word_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (fw.word_ready === 1'b1) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
        end
        #1;
        fw.word_valid = 1'b0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_word: word %0h never accepted within 40 cycles", w);
        end
    endtask

    task automatic check_frame(input string name, input int exp_len, input int exp_val,
                               input int exp_c, input int exp_u);
        int v = 0;
        foreach (line_q[i]) v = (v << 1) | int'(line_q[i]);
        cmp32({name, "_len"}, line_q.size(), exp_len);
        cmp32({name, "_bits"}, v, exp_val);
        cmp32({name, "_complete_cnt"}, cmp_seen, exp_c);
        cmp32({name, "_underrun_cnt"}, und_seen, exp_u);
    endtask

    initial begin
        fw.enable = 1'b1;
        fw.start = 1'b0;
        fw.framesize = '0;
        fw.parallel = '0;
        fw.word_valid = 1'b0;
        clear_obs();

        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        cmp1("rst_busy", fw.busy, 1'b0);
        cmp1("rst_serial_oe", fw.serial_oe, 1'b0);
        cmp1("rst_word_ready", fw.word_ready, 1'b0);
        cmp1("rst_complete", fw.complete, 1'b0);
        cmp1("rst_underrun", fw.underrun, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 8-bit frame of 0xA5; valid held afterwards must not be taken at the last bit.
        clear_obs();
        kick(8'd8, 1'b1);
        send_word(8'hA5);
        fw.parallel = 8'hFF;
        fw.word_valid = 1'b1;
        repeat (12) tick();
        fw.word_valid = 1'b0;
        check_frame("f8_a5", 8, 'hA5, 1, 0);
        cmp32("f8_first_bit_latency", first_oe_cyc - acc_cyc, 1);
        cmp32("f8_complete_latency", cmp_cyc - acc_cyc, 9);

        // 16-bit frame chained from two words; a start while busy is ignored.
        clear_obs();
        kick(8'd16, 1'b1);
        send_word(8'h12);
        fw.framesize = 8'd3;
        fw.start = 1'b1;
        tick();
        fw.start = 1'b0;
        send_word(8'h34);
        repeat (14) tick();
        check_frame("f16_1234", 16, 'h1234, 1, 0);

        // 5-bit frame truncates the word; boundary never reached.
        clear_obs();
        kick(8'd5, 1'b1);
        send_word(8'hF0);
        fw.parallel = 8'h77;
        fw.word_valid = 1'b1;
        repeat (10) tick();
        fw.word_valid = 1'b0;
        check_frame("f5_f0", 5, 'h1E, 1, 0);

        // 16-bit frame starved at the first boundary.
        clear_obs();
        kick(8'd16, 1'b1);
        send_word(8'h3C);
        repeat (14) tick();
        check_frame("f16_underrun", 8, 'h3C, 0, 1);

        // Reset while bit 3 is on the line, then a clean frame.
        clear_obs();
        kick(8'd8, 1'b1);
        send_word(8'h96);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp1("after_rst_busy", fw.busy, 1'b0);
        repeat (3) tick();
        check_frame("f8_reset", 4, 'h9, 0, 0);
        clear_obs();
        kick(8'd8, 1'b1);
        send_word(8'h5A);
        repeat (12) tick();
        check_frame("f8_after_reset", 8, 'h5A, 1, 0);

        // Starts that must be ignored: Enable low, then framesize zero.
        clear_obs();
        kick(8'd8, 1'b0);
        cmp1("en0_busy", fw.busy, 1'b0);
        repeat (3) tick();
        kick(8'd0, 1'b1);
        cmp1("fs0_busy", fw.busy, 1'b0);
        repeat (3) tick();
        check_frame("ignored_starts", 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/parallel_to_serial_framer.md
PARALLEL_TO_SERIAL_FRAMER -- requirements
Module: parallel_to_serial_framer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits.
REQ-002 Parameter FRAME_SIZE_WIDTH, default 8: width of the framesize input and the bit counter.
REQ-003 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Enable  input  1  gates acceptance of start only; a frame already in progress ignores it.
REQ-006 start  input  1  frame request, sampled in IDLE.
REQ-007 framesize  input  FRAME_SIZE_WIDTH  frame length in bits, captured when start is accepted.
REQ-008 parallel  input  WIDTH  data word, transmitted MSB first.
REQ-009 word_valid  input  1  parallel holds a valid word.
REQ-010 word_ready  output  1  framer accepts parallel this cycle; transfer occurs when word_valid and word_ready are both high.
REQ-011 serial  output  1  line bit; driven to 1'bz whenever serial_oe is low.
REQ-012 serial_oe  output  1  high while a frame bit is on the line.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 complete  output  1  one-cycle pulse after the final bit of a frame.
REQ-015 underrun  output  1  one-cycle pulse when a frame aborts for lack of data.

Function
REQ-016 States SHALL be IDLE, FETCH, SHIFT.
REQ-017 IDLE: start and Enable high and framesize != 0 -> latch framesize, clear bit counter, go to FETCH; otherwise stay; framesize == 0 ignores start.
REQ-018 FETCH: word_ready high; on transfer, load the shift register and go to SHIFT; no timeout (waits indefinitely; line stays z).
REQ-019 SHIFT: serial_oe = 1 and serial = shift register MSB; each cycle shift left by one and increment the bit counter and word-bit counter.
REQ-020 Latency: word accepted in cycle N -> its MSB on serial in cycle N+1; subsequent bits on consecutive cycles with no gaps.
REQ-021 word_ready SHALL also be high in the SHIFT cycle carrying bit WIDTH-1 of the current word when more frame bits remain; a transfer then reloads the register so the next word's MSB follows without a gap.
REQ-022 If no transfer occurs at that word boundary: pulse underrun next cycle, serial_oe = 0, return to IDLE (frame aborted).
REQ-023 The SHIFT cycle carrying bit framesize-1 is the last: next cycle complete pulses, serial_oe = 0, state is IDLE; remaining bits of a partial final word are discarded.
REQ-024 The last bit and a word boundary coinciding: frame end wins; word_ready stays low and no underrun.
REQ-025 The bit counter SHALL be FRAME_SIZE_WIDTH bits; the word-bit counter is clog2(WIDTH) bits and wraps at WIDTH.
REQ-026 start asserted while busy SHALL be ignored, not queued.
REQ-027 complete and underrun are never high in the same cycle.

Reset
REQ-028 Reset high SHALL, at the next edge, force IDLE, serial_oe = 0 (serial = z), word_ready = 0, busy = 0, complete = 0, underrun = 0, counters and shift register = 0.
REQ-029 Reset mid-frame aborts without a complete or underrun pulse; Reset has priority over all other inputs.

Structure
REQ-030 A shared package SHALL hold the state enumeration and the default WIDTH/FRAME_SIZE_WIDTH constants used by this block and the serial-to-parallel receiver.
REQ-031 One sub-module, piso_shift_register (parallel load, shift left, MSB out), SHALL be instantiated; control remains in the top.

Verification
REQ-032 framesize=8, word 0xA5 accepted in cycle N -> serial 1,0,1,0,0,1,0,1 in cycles N+1..N+8, serial_oe high there, complete pulse at N+9, serial z from N+9.
REQ-033 framesize=16, words 0x12 then 0x34 (second accepted at the boundary) -> 16 contiguous bits 0x1234 MSB first, one complete pulse.
REQ-034 framesize=5, word 0xF0 -> bits 1,1,1,1,0 then complete; no word_ready at the boundary.
REQ-035 framesize=16, word_valid low at the first boundary -> 8 bits sent, underrun pulse, serial z, no complete.
REQ-036 Reset pulsed at bit 3 of an 8-bit frame -> next cycle IDLE, serial z, no complete/underrun pulse; new start accepted afterward.
REQ-037 start with Enable=0, or with framesize=0 -> stays IDLE, busy low, serial z.
